execute_stage: RTL and testbench

- Pipeline EX stage: computes ALU results and registers them into the EX/MEM pipeline register consumed by the memory stage.
- Contains an iterative 32-step multiply/divide unit with HI/LO registers.
- Asserts a stall toward ID/EX while a HI/LO-dependent instruction waits on the unit.

---
 rtl/execute_stage_pkg.sv | 17 +
 rtl/execute_stage_muldiv_unit.sv | 75 +++++++
 rtl/execute_stage.sv | 107 ++++++++++
 tb/tb_execute_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/execute_stage_pkg.sv
// execute_stage_pkg: shared op codes, muldiv state and helpers for the EX stage
package execute_stage_pkg;
  localparam int MULDIV_STEPS = 32;
  localparam logic [MULDIV_STEPS-1:0] DIV_ZERO_LO = '1;
  typedef enum logic [4:0] {
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_LUI, OP_MFHI, OP_MFLO,
    OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  } alu_op_t;
  typedef enum logic {IDLE, BUSY} muldiv_state_t;
  function automatic logic is_hilo_op(alu_op_t op);
    return op inside {OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction
  function automatic logic is_muldiv_op(alu_op_t op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction
endpackage

// File: rtl/execute_stage_muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider owning HI and LO
module muldiv_unit
  import execute_stage_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    op_signed,
  input  logic                    op_is_div,
  input  logic [MULDIV_STEPS-1:0] a,
  input  logic [MULDIV_STEPS-1:0] b,
  input  logic                    mthi,
  input  logic                    mtlo,
  input  logic [MULDIV_STEPS-1:0] mt_data,
  output logic                    busy,
  output logic [MULDIV_STEPS-1:0] hi,
  output logic [MULDIV_STEPS-1:0] lo
);
  localparam int W = MULDIV_STEPS;
  localparam int CW = $clog2(W + 1);
  muldiv_state_t state;
  logic [CW-1:0] count;
  logic [2*W-1:0] acc, acc_next, prod;
  logic [W-1:0] m, mag_a, mag_b, quo, rem;
  logic [W:0] mul_sum, div_diff;
  logic is_div, neg_q, neg_r, b_zero;
  assign busy = state == BUSY;
  assign mag_a = (op_signed && a[W-1]) ? -a : a;
  assign mag_b = (op_signed && b[W-1]) ? -b : b;
  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, m} : '0);
    div_diff = acc[2*W-1:W-1] - {1'b0, m};
    acc_next = !is_div ? {mul_sum, acc[W-1:1]} :
               div_diff[W] ? {acc[2*W-2:0], 1'b0} : {div_diff[W-1:0], acc[W-2:0], 1'b1};
    prod = neg_q ? -acc_next : acc_next;
    quo = neg_q ? -acc_next[W-1:0] : acc_next[W-1:0];
    rem = neg_r ? -acc_next[2*W-1:W] : acc_next[2*W-1:W];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      acc <= '0;
      m <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      b_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      if (mthi) hi <= mt_data;
      if (mtlo) lo <= mt_data;
      if (state == IDLE && start) begin
        state <= BUSY;
        count <= CW'(W);
        acc <= {{W{1'b0}}, op_is_div ? mag_a : mag_b};
        m <= op_is_div ? mag_b : mag_a;
        is_div <= op_is_div;
        neg_q <= op_signed & (a[W-1] ^ b[W-1]);
        neg_r <= op_signed & a[W-1];
        b_zero <= b == '0;
      end else if (state == BUSY) begin
        count <= count - 1'b1;
        acc <= acc_next;
        if (count == CW'(1)) begin
          state <= IDLE;
          hi <= is_div ? rem : prod[2*W-1:W];
          lo <= is_div ? (b_zero ? DIV_ZERO_LO : quo) : prod[W-1:0];
        end
      end
    end
  end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: ALU, muldiv hookup, HI/LO hazard stall and EX/MEM pipeline register
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_alu_op,
  input  logic [31:0] in_src_a,
  input  logic [31:0] in_src_b,
  input  logic [4:0]  in_shamt,
  input  logic [4:0]  in_dest_reg,
  input  logic        in_reg_write,
  input  logic        in_dm_read,
  input  logic        in_dm_write,
  input  logic [31:0] in_store_data,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_alu_result,
  output logic [4:0]  out_dest_reg,
  output logic        out_reg_write,
  output logic        out_dm_read,
  output logic        out_dm_write,
  output logic [31:0] out_store_data,
  output logic        out_overflow,
  output logic        muldiv_busy
);
  alu_op_t op;
  logic accept, ovf, no_gpr;
  logic [31:0] hi, lo, sum, diff, result;
  assign op = alu_op_t'(in_alu_op);
  assign stall = in_valid & muldiv_busy & is_hilo_op(op);
  assign accept = in_valid & ~stall;
  assign no_gpr = is_muldiv_op(op) | (op == OP_MTHI) | (op == OP_MTLO);
  muldiv_unit u_muldiv (
    .clock(clock),
    .reset(reset),
    .start(accept & is_muldiv_op(op)),
    .op_signed(op == OP_MULT || op == OP_DIV),
    .op_is_div(op == OP_DIV || op == OP_DIVU),
    .a(in_src_a),
    .b(in_src_b),
    .mthi(accept && op == OP_MTHI),
    .mtlo(accept && op == OP_MTLO),
    .mt_data(in_src_a),
    .busy(muldiv_busy),
    .hi(hi),
    .lo(lo)
  );
  always_comb begin
    sum = in_src_a + in_src_b;
    diff = in_src_a - in_src_b;
    result = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum;
        ovf = (in_src_a[31] == in_src_b[31]) && (sum[31] != in_src_a[31]);
      end
      OP_ADDU: result = sum;
      OP_SUB: begin
        result = diff;
        ovf = (in_src_a[31] != in_src_b[31]) && (diff[31] != in_src_a[31]);
      end
      OP_SUBU: result = diff;
      OP_AND:  result = in_src_a & in_src_b;
      OP_OR:   result = in_src_a | in_src_b;
      OP_XOR:  result = in_src_a ^ in_src_b;
      OP_NOR:  result = ~(in_src_a | in_src_b);
      OP_SLT:  result = {31'b0, $signed(in_src_a) < $signed(in_src_b)};
      OP_SLTU: result = {31'b0, in_src_a < in_src_b};
      OP_SLL:  result = in_src_b << in_shamt;
      OP_SRL:  result = in_src_b >> in_shamt;
      OP_SRA:  result = $signed(in_src_b) >>> in_shamt;
      OP_LUI:  result = {in_src_b[15:0], 16'h0};
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      default: result = '0;
    endcase
  end
  // stalled or empty slots enter EX/MEM as an all-zero bubble
  always_ff @(posedge clock) begin
    if (reset || !accept) begin
      out_valid <= 1'b0;
      out_pc <= '0;
      out_alu_result <= '0;
      out_dest_reg <= '0;
      out_reg_write <= 1'b0;
      out_dm_read <= 1'b0;
      out_dm_write <= 1'b0;
      out_store_data <= '0;
      out_overflow <= 1'b0;
    end else begin
      out_valid <= 1'b1;
      out_pc <= in_pc;
      out_alu_result <= result;
      out_dest_reg <= in_dest_reg;
      out_reg_write <= in_reg_write & ~ovf & ~no_gpr;
      out_dm_read <= in_dm_read;
      out_dm_write <= in_dm_write;
      out_store_data <= in_store_data;
      out_overflow <= ovf;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: randomized scoreboard bench with a behavioural EX-stage model
module tb_execute_stage;
  import execute_stage_pkg::*;
  logic clock = 1'b0, reset = 1'b1, in_valid = 1'b0;
  logic [31:0] in_pc = '0, in_src_a = '0, in_src_b = '0, in_store_data = '0;
  logic [4:0] in_alu_op = '0, in_shamt = '0, in_dest_reg = '0;
  logic in_reg_write = 1'b0, in_dm_read = 1'b0, in_dm_write = 1'b0;
  logic stall, out_valid, out_reg_write, out_dm_read, out_dm_write, out_overflow, muldiv_busy;
  logic [31:0] out_pc, out_alu_result, out_store_data;
  logic [4:0] out_dest_reg;
  execute_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
    .in_alu_op(in_alu_op), .in_src_a(in_src_a), .in_src_b(in_src_b),
    .in_shamt(in_shamt), .in_dest_reg(in_dest_reg), .in_reg_write(in_reg_write),
    .in_dm_read(in_dm_read), .in_dm_write(in_dm_write), .in_store_data(in_store_data),
    .stall(stall), .out_valid(out_valid), .out_pc(out_pc), .out_alu_result(out_alu_result),
    .out_dest_reg(out_dest_reg), .out_reg_write(out_reg_write), .out_dm_read(out_dm_read),
    .out_dm_write(out_dm_write), .out_store_data(out_store_data),
    .out_overflow(out_overflow), .muldiv_busy(muldiv_busy)
  );
  always #5 clock = ~clock;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] res;
    logic chk_res;
    logic [4:0] dest;
    logic rw, rd, wr;
    logic [31:0] sd;
    logic ovf;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0, mrem = 0, s;
  logic [31:0] m_hi = '0, m_lo = '0, pc_ctr = 32'h0040_0000;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  always @(negedge clock) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_output: got pc %h expected no output", out_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_pc", out_pc, e.pc);
        if (e.chk_res) check("out_alu_result", out_alu_result, e.res);
        check("flags{dest,rw,rd,wr,ovf}", {out_dest_reg, out_reg_write, out_dm_read, out_dm_write, out_overflow},
              {e.dest, e.rw, e.rd, e.wr, e.ovf});
        check("out_store_data", out_store_data, e.sd);
      end
    end
  end
  task automatic tick(input bit start);
    @(posedge clock);
    if (mrem > 0) mrem--;
    if (start) mrem = 32;
    #1;
  endtask
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick(0);
  endtask
  task automatic issue(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output int stalls);
    exp_t e;
    longint sw;
    longint unsigned uw;
    int sa, sb;
    bit hl, md;
    hl = op inside {OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    md = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    in_valid = 1'b1; in_pc = pc_ctr; in_alu_op = op; in_src_a = a; in_src_b = b; in_shamt = sh;
    in_dest_reg = 5'($urandom); in_reg_write = 1'($urandom); in_dm_read = 1'($urandom);
    in_dm_write = 1'($urandom); in_store_data = $urandom;
    stalls = 0;
    #1;
    while (hl && mrem > 0) begin
      check("stall_while_busy", stall, 1);
      stalls++;
      tick(0);
    end
    check("stall_when_free", stall, 0);
    e = '0;
    e.pc = in_pc; e.dest = in_dest_reg; e.rd = in_dm_read; e.wr = in_dm_write; e.sd = in_store_data;
    e.chk_res = 1'b1;
    sa = a; sb = b;
    case (op)
      OP_ADD, OP_SUB: begin
        sw = (op == OP_ADD) ? longint'(sa) + longint'(sb) : longint'(sa) - longint'(sb);
        e.res = sw[31:0];
        e.ovf = sw > 64'sd2147483647 || sw < -64'sd2147483648;
      end
      OP_ADDU: e.res = a + b;
      OP_SUBU: e.res = a - b;
      OP_AND:  e.res = a & b;
      OP_OR:   e.res = a | b;
      OP_XOR:  e.res = a ^ b;
      OP_NOR:  e.res = ~(a | b);
      OP_SLT:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: e.res = (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  e.res = 32'(longint'(b) * (longint'(1) << sh));
      OP_SRL:  e.res = b / (32'd1 << sh);
      OP_SRA:  begin sw = longint'(sb) >>> sh; e.res = sw[31:0]; end
      OP_LUI:  e.res = 32'(b * 65536);
      OP_MFHI: e.res = m_hi;
      OP_MFLO: e.res = m_lo;
      OP_MTHI: begin m_hi = a; e.chk_res = 1'b0; end
      OP_MTLO: begin m_lo = a; e.chk_res = 1'b0; end
      OP_MULT: begin sw = longint'(sa) * longint'(sb); {m_hi, m_lo} = sw; e.chk_res = 1'b0; end
      OP_MULTU: begin uw = longint'({32'b0, a}) * longint'({32'b0, b}); {m_hi, m_lo} = uw; e.chk_res = 1'b0; end
      OP_DIV: begin
        e.chk_res = 1'b0;
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = 0; end
        else begin m_lo = sa / sb; m_hi = sa % sb; end
      end
      default: begin
        e.chk_res = 1'b0;
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
    endcase
    e.rw = in_reg_write && !e.ovf && !(md || op == OP_MTHI || op == OP_MTLO);
    q.push_back(e);
    tick(md);
    in_valid = 1'b0;
    pc_ctr += 4;
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    tick(0); tick(0);
    reset = 1'b0;
    check("reset_state", {out_valid, out_pc, out_alu_result, out_reg_write, out_overflow, stall, muldiv_busy}, 0);
    issue(OP_MFHI, 0, 0, 0, s);
    issue(OP_ADD, 32'h7FFF_FFFF, 1, 0, s);
    issue(OP_ADDU, 32'h7FFF_FFFF, 1, 0, s);
    issue(OP_SUB, 32'h8000_0000, 1, 0, s);
    issue(OP_SRA, 0, 32'h8000_0000, 4, s);
    issue(OP_SLT, 32'hFFFF_FFFF, 1, 0, s);
    issue(OP_SLTU, 32'hFFFF_FFFF, 1, 0, s);
    issue(OP_LUI, 0, 32'h0000_1234, 0, s);
    issue(OP_MULT, 32'hFFFF_FFFF, 2, 0, s);
    issue(OP_MFLO, 0, 0, 0, s);
    check("mult_stall_cycles", s, 32);
    issue(OP_MFHI, 0, 0, 0, s);
    issue(OP_MULTU, 32'hFFFF_FFFF, 2, 0, s);
    issue(OP_MFHI, 0, 0, 0, s);
    issue(OP_MFLO, 0, 0, 0, s);
    issue(OP_DIV, 32'hFFFF_FFF9, 2, 0, s);
    issue(OP_MFLO, 0, 0, 0, s);
    issue(OP_MFHI, 0, 0, 0, s);
    issue(OP_DIVU, 5, 0, 0, s);
    issue(OP_MFLO, 0, 0, 0, s);
    issue(OP_MFHI, 0, 0, 0, s);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, s);
    issue(OP_MFLO, 0, 0, 0, s);
    issue(OP_MFHI, 0, 0, 0, s);
    issue(OP_DIV, 100, 7, 0, s);
    issue(OP_ADDU, 3, 4, 0, s);
    check("busy_during_div", muldiv_busy, 1);
    idle(40);
    issue(OP_MTHI, 32'hDEAD_BEEF, 0, 0, s);
    issue(OP_MTLO, 32'h1234_5678, 0, 0, s);
    issue(OP_MFHI, 0, 0, 0, s);
    issue(OP_MFLO, 0, 0, 0, s);
    issue(OP_DIV, 1000, 3, 0, s);
    idle(9);
    reset = 1'b1;
    tick(0);
    reset = 1'b0;
    mrem = 0; m_hi = '0; m_lo = '0;
    q.delete();
    check("reset_abort{busy,valid,stall}", {muldiv_busy, out_valid, stall}, 0);
    issue(OP_MFHI, 0, 0, 0, s);
    check("post_reset_no_stall", s, 0);
    issue(OP_MFLO, 0, 0, 0, s);
    for (int i = 0; i < 200; i++) begin
      issue(alu_op_t'($urandom_range(0, 21)), pick(), pick(), 5'($urandom), s);
      idle($urandom_range(0, 1));
    end
    idle(40);
    check("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
